// File: rtl/aes_pin_bridge_if.sv
// Pin-side host port and AES core streams of the AES pin bridge.
// slave: bridge side; master: host/core driver side.
interface aes_pin_bridge_if #(
  parameter int ADDR_W = 24
);
  logic [7:0]        pin_data;
  logic              pin_strobe;
  logic              pin_pop;
  logic [7:0]        pin_out;
  logic [7:0]        status;
  logic [7:0]        core_data;
  logic              core_valid;
  logic              core_ready;
  logic [7:0]        core_rdata;
  logic              core_rvalid;
  logic              core_rready;
  logic              core_ack_valid;
  logic              core_ack_ready;
  logic [1:0]        opcode;
  logic [1:0]        source_id;
  logic [1:0]        dest_id;
  logic              encdec;
  logic [ADDR_W-1:0] addr;

  modport slave (
    input  pin_data, pin_strobe, pin_pop,
    input  core_ready, core_rdata, core_rvalid,
    input  core_ack_valid,
    output pin_out, status,
    output core_data, core_valid, core_rready,
    output core_ack_ready,
    output opcode, source_id, dest_id, encdec, addr
  );

  modport master (
    output pin_data, pin_strobe, pin_pop,
    output core_ready, core_rdata, core_rvalid,
    output core_ack_valid,
    input  pin_out, status,
    input  core_data, core_valid, core_rready,
    input  core_ack_ready,
    input  opcode, source_id, dest_id, encdec, addr
  );
endinterface

// File: rtl/aes_pin_bridge.sv
// Byte-wide pin bridge: parses header/addr/len/payload into an AES
// core stream, buffers core results for the host, tracks the ack.
// Ports: clk, rst (sync, active-high), bus (aes_pin_bridge_if.slave).
module aes_pin_bridge #(
  parameter int IN_DEPTH  = 16,
  parameter int OUT_DEPTH = 16,
  parameter int ADDR_W    = 24
) (
  input  logic clk,
  input  logic rst,
  aes_pin_bridge_if.slave bus
);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int NB  = ADDR_W / 8;
  localparam logic [IAW:0] IN_FULL  = IN_DEPTH[IAW:0];
  localparam logic [OAW:0] OUT_FULL = OUT_DEPTH[OAW:0];
  localparam logic [1:0]   LAST_AB  = 2'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_PAYLOAD, S_DRAIN, S_WAIT_ACK
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        opcode_q, opcode_d;
  logic [1:0]        src_q, src_d;
  logic [1:0]        dst_q, dst_d;
  logic              encdec_q, encdec_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        abyte_q, abyte_d;
  logic [8:0]        cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              ack_q, ack_d;

  logic [IAW-1:0]    in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [IAW:0]      in_cnt_q, in_cnt_d;
  logic [OAW-1:0]    out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [OAW:0]      out_cnt_q, out_cnt_d;

  logic [7:0] in_mem  [IN_DEPTH];
  logic [7:0] out_mem [OUT_DEPTH];

  logic in_empty, in_full, in_push, in_pop, pay_stb;
  logic out_empty, out_full, out_push, out_pop;

  always_comb begin
    in_empty  = (in_cnt_q == '0);
    in_full   = (in_cnt_q == IN_FULL);
    out_empty = (out_cnt_q == '0);
    out_full  = (out_cnt_q == OUT_FULL);
    in_pop    = !in_empty && bus.core_ready;
    pay_stb   = (state_q == S_PAYLOAD) && bus.pin_strobe;
    // a full FIFO still takes a byte when its head leaves this cycle
    in_push   = pay_stb && (!in_full || in_pop);
    out_push  = bus.core_rvalid && !out_full;
    out_pop   = bus.pin_pop && !out_empty;
  end

  always_comb begin
    in_wr_d  = in_push ? in_wr_q + 1'b1 : in_wr_q;
    in_rd_d  = in_pop ? in_rd_q + 1'b1 : in_rd_q;
    out_wr_d = out_push ? out_wr_q + 1'b1 : out_wr_q;
    out_rd_d = out_pop ? out_rd_q + 1'b1 : out_rd_q;
    unique case ({in_push, in_pop})
      2'b10:   in_cnt_d = in_cnt_q + 1'b1;
      2'b01:   in_cnt_d = in_cnt_q - 1'b1;
      default: in_cnt_d = in_cnt_q;
    endcase
    unique case ({out_push, out_pop})
      2'b10:   out_cnt_d = out_cnt_q + 1'b1;
      2'b01:   out_cnt_d = out_cnt_q - 1'b1;
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    src_d    = src_q;
    dst_d    = dst_q;
    encdec_d = encdec_q;
    addr_d   = addr_q;
    abyte_d  = abyte_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q | (pay_stb && !in_push);
    ack_d    = ack_q;
    unique case (state_q)
      S_IDLE: if (bus.pin_strobe) begin
        encdec_d = bus.pin_data[6];
        dst_d    = bus.pin_data[5:4];
        src_d    = bus.pin_data[3:2];
        opcode_d = bus.pin_data[1:0];
        addr_d   = '0;
        abyte_d  = '0;
        ack_d    = 1'b0;
        state_d  = S_ADDR;
      end
      S_ADDR: if (bus.pin_strobe) begin
        addr_d  = (addr_q << 8) | ADDR_W'(bus.pin_data);
        abyte_d = abyte_q + 1'b1;
        if (abyte_q == LAST_AB) state_d = S_LEN;
      end
      S_LEN: if (bus.pin_strobe) begin
        // zero length encodes a full 256-byte block
        cnt_d   = {bus.pin_data == 8'h00, bus.pin_data};
        state_d = S_PAYLOAD;
      end
      S_PAYLOAD: if (in_push) begin
        cnt_d = cnt_q - 9'd1;
        if (cnt_q == 9'd1) state_d = S_DRAIN;
      end
      S_DRAIN: if (in_empty) state_d = S_WAIT_ACK;
      S_WAIT_ACK: if (bus.core_ack_valid) begin
        ack_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      encdec_q  <= 1'b0;
      addr_q    <= '0;
      abyte_q   <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      ack_q     <= 1'b0;
      in_wr_q   <= '0;
      in_rd_q   <= '0;
      in_cnt_q  <= '0;
      out_wr_q  <= '0;
      out_rd_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      encdec_q  <= encdec_d;
      addr_q    <= addr_d;
      abyte_q   <= abyte_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      ack_q     <= ack_d;
      in_wr_q   <= in_wr_d;
      in_rd_q   <= in_rd_d;
      in_cnt_q  <= in_cnt_d;
      out_wr_q  <= out_wr_d;
      out_rd_q  <= out_rd_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr_q] <= bus.pin_data;
    if (out_push) out_mem[out_wr_q] <= bus.core_rdata;
  end

  // outputs are forced quiet while reset is held
  always_comb begin
    bus.core_valid     = !rst && !in_empty;
    bus.core_data      = (rst || in_empty) ? 8'h00 : in_mem[in_rd_q];
    bus.core_rready    = !rst && !out_full;
    bus.core_ack_ready = !rst && (state_q == S_WAIT_ACK);
    bus.pin_out        = (rst || out_empty) ? 8'h00 : out_mem[out_rd_q];
    bus.status         = rst ? 8'h00 :
                         {3'b000, ack_q, ovf_q, !out_empty,
                          in_full, state_q != S_IDLE};
    bus.opcode         = rst ? 2'b00 : opcode_q;
    bus.source_id      = rst ? 2'b00 : src_q;
    bus.dest_id        = rst ? 2'b00 : dst_q;
    bus.encdec         = !rst && encdec_q;
    bus.addr           = rst ? '0 : addr_q;
  end
endmodule

// File: tb/tb_aes_pin_bridge.sv
// Randomized scoreboard bench for aes_pin_bridge.
// Queue-based reference model; monitors compare core_data and pin_out.
module tb_aes_pin_bridge;
  localparam int IN_DEPTH  = 16;
  localparam int OUT_DEPTH = 16;
  localparam int ADDR_W    = 24;
  localparam int NB        = ADDR_W / 8;

  logic clk = 1'b0;
  logic rst;

  aes_pin_bridge_if #(.ADDR_W(ADDR_W)) bus ();

  aes_pin_bridge #(
    .IN_DEPTH(IN_DEPTH),
    .OUT_DEPTH(OUT_DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] exp_core [$];
  logic [7:0] exp_out  [$];
  int m_in_occ  = 0;
  int m_out_occ = 0;
  int m_rem     = 0;
  bit m_ovf     = 0;
  bit m_ack     = 0;
  bit m_push_in = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // scoreboard monitors: compare whenever the DUT hands a byte over
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.core_valid && bus.core_ready) begin
        if (exp_core.size() == 0) begin
          n_chk++;
          $display("FAIL core_extra: got 0x%0h, want no byte",
                   bus.core_data);
        end else chk("core_data", bus.core_data, exp_core.pop_front());
      end
      if (bus.pin_pop && bus.status[2]) begin
        if (exp_out.size() == 0) begin
          n_chk++;
          $display("FAIL pin_out_extra: got 0x%0h, want no byte",
                   bus.pin_out);
        end else chk("pin_out", bus.pin_out, exp_out.pop_front());
      end
    end
  end

  // advance the reference model over one clock and check the flags
  task automatic step();
    bit ip, op, opush;
    if (rst) begin
      m_in_occ  = 0;
      m_out_occ = 0;
      m_rem     = 0;
      m_ovf     = 0;
      m_ack     = 0;
      exp_core.delete();
      exp_out.delete();
    end else begin
      ip       = (m_in_occ > 0) && bus.core_ready;
      m_in_occ = m_in_occ + int'(m_push_in) - int'(ip);
      opush    = bus.core_rvalid && (m_out_occ < OUT_DEPTH);
      if (opush) exp_out.push_back(bus.core_rdata);
      op        = bus.pin_pop && (m_out_occ > 0);
      m_out_occ = m_out_occ + int'(opush) - int'(op);
    end
    m_push_in = 0;
    @(posedge clk);
    #1;
    bus.pin_strobe     = 1'b0;
    bus.pin_pop        = 1'b0;
    bus.core_ack_valid = 1'b0;
    chk("flags",
        {bus.core_valid, bus.core_rready, bus.status[3:1]},
        {!rst && m_in_occ > 0, !rst && m_out_occ < OUT_DEPTH,
         !rst && m_ovf, !rst && m_out_occ > 0,
         !rst && m_in_occ == IN_DEPTH});
  endtask

  task automatic ctl(input logic [7:0] b);
    bus.pin_data   = b;
    bus.pin_strobe = 1'b1;
    bus.core_ready = 1'($urandom_range(0, 1));
    step();
  endtask

  task automatic send_header(input logic [7:0] hdr,
                             input logic [ADDR_W-1:0] a, input int len);
    ctl(hdr);
    m_ack = 0;
    chk("ack_clear", bus.status[4], 0);
    chk("busy_hdr", bus.status[0], 1);
    for (int i = NB - 1; i >= 0; i--) ctl(a[8*i +: 8]);
    ctl(8'(len));
    m_rem = len;
    chk("opcode", bus.opcode, hdr[1:0]);
    chk("source_id", bus.source_id, hdr[3:2]);
    chk("dest_id", bus.dest_id, hdr[5:4]);
    chk("encdec", bus.encdec, hdr[6]);
    chk("addr", bus.addr, a);
  endtask

  task automatic send_payload(input int n, input bit seq,
                              input int rdy_pct, input int stb_pct);
    int i = 0;
    logic [7:0] b;
    bit acc;
    while (m_rem > 0 && i < n) begin
      bus.core_ready = ($urandom_range(0, 99) < rdy_pct);
      if ($urandom_range(0, 99) < stb_pct) begin
        b = seq ? 8'hAA + 8'(17 * i) : 8'($urandom);
        bus.pin_data   = b;
        bus.pin_strobe = 1'b1;
        acc = (m_in_occ < IN_DEPTH) ||
              (m_in_occ > 0 && bus.core_ready);
        if (acc) begin
          exp_core.push_back(b);
          m_push_in = 1;
          m_rem--;
        end else m_ovf = 1;
        i++;
      end
      step();
    end
  endtask

  task automatic finish_txn();
    int g = 0;
    // strobes while draining must be ignored
    while (m_in_occ > 0 && g < 2000) begin
      bus.core_ready = 1'($urandom_range(0, 1));
      bus.pin_data   = 8'($urandom);
      bus.pin_strobe = 1'($urandom_range(0, 1));
      step();
      g++;
    end
    chk("drain_bound", g < 2000, 1);
    chk("ack_rdy_drain", bus.core_ack_ready, 0);
    chk("busy_drain", bus.status[0], 1);
    step();
    repeat ($urandom_range(0, 2)) begin
      chk("ack_rdy_wait", bus.core_ack_ready, 1);
      step();
    end
    bus.core_ack_valid = 1'b1;
    chk("ack_rdy", bus.core_ack_ready, 1);
    step();
    m_ack = 1;
    chk("busy_after_ack", bus.status[0], 0);
    chk("ack_seen", bus.status[4], 1);
    chk("ack_rdy_idle", bus.core_ack_ready, 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_status"}, bus.status, 0);
    chk({tag, "_pin_out"}, bus.pin_out, 0);
    chk({tag, "_core"},
        {bus.core_valid, bus.core_rready, bus.core_ack_ready,
         bus.core_data}, 0);
    chk({tag, "_cmd"},
        {bus.opcode, bus.source_id, bus.dest_id, bus.encdec, bus.addr},
        0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, want finish");
    $fatal(1);
  end

  initial begin
    bus.pin_data       = 8'h00;
    bus.pin_strobe     = 1'b0;
    bus.pin_pop        = 1'b0;
    bus.core_ready     = 1'b0;
    bus.core_rdata     = 8'h00;
    bus.core_rvalid    = 1'b0;
    bus.core_ack_valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    chk_reset_outs("rst");
    rst = 1'b0;
    step();
    chk("post_rst_status", bus.status, 0);
    chk("post_rst_rready", bus.core_rready, 1);

    // header 0x4D, addr 0x123456, three bytes AA BB CC
    send_header(8'h4D, 24'h123456, 3);
    chk("vec_cmd",
        {bus.opcode, bus.source_id, bus.dest_id, bus.encdec},
        {2'd1, 2'd3, 2'd0, 1'b1});
    chk("vec_addr", bus.addr, 24'h123456);
    send_payload(3, 1, 100, 100);
    finish_txn();

    // overflow: core stalled, 20 strobes into a 16-deep FIFO
    send_header(8'($urandom), ADDR_W'($urandom), 20);
    send_payload(16, 0, 0, 100);
    chk("in_full_16", bus.status[1], 1);
    chk("ovf_before", bus.status[3], 0);
    send_payload(4, 0, 0, 100);
    chk("ovf_sticky", bus.status[3], 1);
    chk("busy_owed", bus.status[0], 1);
    send_payload(4, 0, 100, 100);
    finish_txn();
    chk("ovf_held", bus.status[3], 1);

    // reset with five bytes buffered mid-payload
    send_header(8'($urandom), ADDR_W'($urandom), 10);
    send_payload(5, 0, 0, 100);
    chk("buffered", bus.core_valid, 1);
    rst = 1'b1;
    step();
    chk_reset_outs("mid_rst");
    rst = 1'b0;
    step();
    chk("after_rst_status", bus.status, 0);
    send_header(8'($urandom), ADDR_W'($urandom), 7);
    send_payload(200, 0, 60, 80);
    finish_txn();

    // result FIFO fills with 0x01..0x10, 0x11 is refused
    for (int v = 1; v <= 16; v++) begin
      bus.core_rdata  = 8'(v);
      bus.core_rvalid = 1'b1;
      step();
    end
    chk("out_head", bus.pin_out, 8'h01);
    bus.core_rdata = 8'h11;
    step();
    chk("out_full_rready", bus.core_rready, 0);
    chk("out_head_held", bus.pin_out, 8'h01);
    bus.core_rvalid = 1'b0;
    bus.pin_pop     = 1'b1;
    step();
    chk("out_head_next", bus.pin_out, 8'h02);
    chk("out_rready_back", bus.core_rready, 1);

    // random push/pop traffic on the result FIFO
    repeat (300) begin
      bus.core_rvalid = 1'($urandom_range(0, 1));
      bus.core_rdata  = 8'($urandom);
      bus.pin_pop     = ($urandom_range(0, 9) < 4);
      step();
    end
    bus.core_rvalid = 1'b0;
    for (int g = 0; g < 64 && m_out_occ > 0; g++) begin
      bus.pin_pop = 1'b1;
      step();
    end
    chk("out_empty_pin", bus.pin_out, 8'h00);

    // random transactions
    repeat (8) begin
      send_header(8'($urandom), ADDR_W'($urandom),
                  $urandom_range(1, 40));
      send_payload(2000, 0, $urandom_range(20, 100),
                   $urandom_range(30, 100));
      chk("payload_done", m_rem == 0, 1);
      finish_txn();
    end

    // length byte 0 carries 256 payload bytes
    send_header(8'($urandom), ADDR_W'($urandom), 256);
    send_payload(256, 0, 100, 100);
    finish_txn();

    chk("core_sb_empty", exp_core.size(), 0);
    chk("out_sb_empty", exp_out.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
